// File: rtl/lcd_cmd_feeder.sv
// lcd_cmd_feeder: buffers host LCD commands in a FIFO and issues them
// one at a time to LCD_CTRL, pacing each issue on the busy handshake.
//
// Ports:
//   clk, reset          clock; async active-high reset
//   in_cmd/in_valid     host command offer
//   in_ready            FIFO can accept (combinational)
//   cmd/cmd_valid       registered command and one-cycle issue strobe
//   busy, done          LCD_CTRL status
//   fifo_count          entries held
//   issued_cnt          commands issued since reset (wraps)
//   cmd_err             sticky busy-timeout flag
//   finished            sticky, done has been seen
module lcd_cmd_feeder #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               in_cmd,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [3:0]               cmd,
  output logic                     cmd_valid,
  input  logic                     busy,
  input  logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               issued_cnt,
  output logic                     cmd_err,
  output logic                     finished
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_n;
  logic            issue;
  logic            err_set;

  logic [3:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            push;
  logic [3:0]      head;

  assign full     = (fifo_count == CW'(DEPTH));
  assign in_ready = !full && !finished;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  // Next-state logic. A done seen this edge suppresses an issue;
  // once finished is registered the FSM is parked in IDLE.
  always_comb begin
    state_n = state;
    timer_n = timer;
    issue   = 1'b0;
    err_set = 1'b0;
    if (finished) begin
      state_n = IDLE;
      timer_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!done && fifo_count != '0 && !busy) begin
            issue   = 1'b1;
            timer_n = '0;
            state_n = WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (busy) begin
            state_n = WAIT_LO;
          end else if (timer == TMAX) begin
            err_set = 1'b1;
            state_n = IDLE;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!busy) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end

  // Storage has no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (finished) begin
      // Flush: in_ready is low here, so no push can race this.
      rd_ptr     <= wr_ptr;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, issue})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd        <= '0;
      cmd_valid  <= 1'b0;
      issued_cnt <= '0;
      cmd_err    <= 1'b0;
      finished   <= 1'b0;
    end else begin
      cmd_valid <= issue;
      if (issue) begin
        cmd        <= head;
        issued_cnt <= issued_cnt + 1'b1;
      end
      if (err_set) cmd_err <= 1'b1;
      if (done) finished <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_feeder.sv
// tb_lcd_cmd_feeder: directed bench for lcd_cmd_feeder.
// Reactive busy model plus a monitor collecting issued commands.
module tb_lcd_cmd_feeder;

  localparam int DEPTH = 16;
  localparam int BT    = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_cmd;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic [4:0] fifo_count;
  logic [7:0] issued_cnt;
  logic       cmd_err;
  logic       finished;

  logic       busy_auto;
  logic       busy_man;
  logic       model_busy;
  int         bcnt;
  logic       prev_valid;
  logic [3:0] seen [$];

  int total  = 0;
  int passed = 0;

  assign busy = busy_auto ? model_busy : busy_man;

  lcd_cmd_feeder #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_cmd     (in_cmd),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count),
    .issued_cnt (issued_cnt),
    .cmd_err    (cmd_err),
    .finished   (finished)
  );

  always #5 clk = ~clk;

  // busy rises the cycle after cmd_valid and is sampled high 4 edges
  always @(posedge clk) begin
    #1;
    if (reset) begin
      model_busy = 1'b0;
      bcnt = 0;
    end else if (cmd_valid) begin
      model_busy = 1'b1;
      bcnt = 4;
    end else if (bcnt > 0) begin
      bcnt = bcnt - 1;
      if (bcnt == 0) model_busy = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmd_valid) begin
      seen.push_back(cmd);
      total++;
      if (prev_valid)
        $display("FAIL single_strobe: cmd_valid high 2 cycles, want 1");
      else passed++;
    end
    prev_valid = cmd_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_cmd = '0;
    done = 1'b0;
    busy_auto = 1'b0;
    busy_man = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    seen.delete();
  endtask

  task automatic test_reset();
    model_busy = 1'b0;
    bcnt = 0;
    prev_valid = 1'b0;
    do_reset();
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (cmd !== 4'd0) $display("FAIL rst_cmd: got %0d want 0", cmd); else passed++;
    total++; if (cmd_valid !== 1'b0) $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); else passed++;
    total++; if (fifo_count !== 5'd0) $display("FAIL rst_count: got %0d want 0", fifo_count); else passed++;
    total++; if (issued_cnt !== 8'd0) $display("FAIL rst_issued: got %0d want 0", issued_cnt); else passed++;
    total++; if (cmd_err !== 1'b0) $display("FAIL rst_err: got %b want 0", cmd_err); else passed++;
    total++; if (finished !== 1'b0) $display("FAIL rst_finished: got %b want 0", finished); else passed++;
  endtask

  task automatic test_basic();
    logic [3:0] exp [3] = '{4'd3, 4'd5, 4'd0};
    do_reset();
    busy_auto = 1'b1;
    in_valid = 1'b1;
    in_cmd = 4'd3;
    tick();
    total++; if (fifo_count !== 5'd1) $display("FAIL basic_count1: got %0d want 1", fifo_count); else passed++;
    total++; if (cmd_valid !== 1'b0) $display("FAIL basic_nobypass: got %b want 0", cmd_valid); else passed++;
    in_cmd = 4'd5;
    tick();
    total++; if (cmd_valid !== 1'b1 || cmd !== 4'd3)
      $display("FAIL basic_first: got v=%b cmd=%0d want v=1 cmd=3", cmd_valid, cmd);
    else passed++;
    total++; if (fifo_count !== 5'd1) $display("FAIL basic_count2: got %0d want 1", fifo_count); else passed++;
    in_cmd = 4'd0;
    tick();
    in_valid = 1'b0;
    repeat (40) tick();
    total++; if (seen.size() !== 3) $display("FAIL basic_n: got %0d want 3", seen.size()); else passed++;
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      total++;
      if (seen[i] !== exp[i]) $display("FAIL basic_seq[%0d]: got %0d want %0d", i, seen[i], exp[i]);
      else passed++;
    end
    total++; if (issued_cnt !== 8'd3) $display("FAIL basic_issued: got %0d want 3", issued_cnt); else passed++;
    total++; if (fifo_count !== 5'd0) $display("FAIL basic_drain: got %0d want 0", fifo_count); else passed++;
  endtask

  task automatic test_full();
    do_reset();
    busy_man = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_cmd = 4'(i * 5 + 3);
      in_valid = 1'b1;
      tick();
      if (i == DEPTH - 1) begin
        total++; if (in_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", in_ready); else passed++;
      end
    end
    in_valid = 1'b0;
    total++; if (fifo_count !== 5'(DEPTH)) $display("FAIL full_count: got %0d want %0d", fifo_count, DEPTH); else passed++;
    busy_auto = 1'b1;
    repeat (130) tick();
    total++; if (seen.size() !== DEPTH) $display("FAIL full_n: got %0d want %0d", seen.size(), DEPTH); else passed++;
    for (int i = 0; i < DEPTH && i < seen.size(); i++) begin
      total++;
      if (seen[i] !== 4'(i * 5 + 3))
        $display("FAIL full_seq[%0d]: got %0d want %0d", i, seen[i], 4'(i * 5 + 3));
      else passed++;
    end
    total++; if (fifo_count !== 5'd0) $display("FAIL full_drain: got %0d want 0", fifo_count); else passed++;
  endtask

  task automatic test_simul();
    logic [3:0] exp [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9};
    do_reset();
    busy_man = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_cmd = 4'(i);
      tick();
    end
    total++; if (fifo_count !== 5'd4) $display("FAIL simul_pre: got %0d want 4", fifo_count); else passed++;
    in_cmd = 4'd9;
    busy_man = 1'b0;
    tick();
    in_valid = 1'b0;
    busy_auto = 1'b1;
    total++; if (fifo_count !== 5'd4) $display("FAIL simul_count: got %0d want 4", fifo_count); else passed++;
    total++; if (cmd_valid !== 1'b1 || cmd !== 4'd1)
      $display("FAIL simul_issue: got v=%b cmd=%0d want v=1 cmd=1", cmd_valid, cmd);
    else passed++;
    repeat (40) tick();
    total++; if (seen.size() !== 5) $display("FAIL simul_n: got %0d want 5", seen.size()); else passed++;
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      total++;
      if (seen[i] !== exp[i]) $display("FAIL simul_seq[%0d]: got %0d want %0d", i, seen[i], exp[i]);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    in_valid = 1'b1;
    in_cmd = 4'd6;
    tick();
    in_cmd = 4'd10;
    tick();
    in_valid = 1'b0;
    total++; if (cmd_valid !== 1'b1 || cmd !== 4'd6)
      $display("FAIL to_issue: got v=%b cmd=%0d want v=1 cmd=6", cmd_valid, cmd);
    else passed++;
    repeat (BT - 1) tick();
    total++; if (cmd_err !== 1'b0) $display("FAIL to_early: got %b want 0", cmd_err); else passed++;
    tick();
    total++; if (cmd_err !== 1'b1) $display("FAIL to_err: got %b want 1", cmd_err); else passed++;
    total++; if (cmd_valid !== 1'b0) $display("FAIL to_gap: got %b want 0", cmd_valid); else passed++;
    tick();
    total++; if (cmd_valid !== 1'b1 || cmd !== 4'd10)
      $display("FAIL to_next: got v=%b cmd=%0d want v=1 cmd=10", cmd_valid, cmd);
    else passed++;
    total++; if (issued_cnt !== 8'd2) $display("FAIL to_issued: got %0d want 2", issued_cnt); else passed++;
  endtask

  task automatic test_done();
    do_reset();
    busy_man = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_cmd = 4'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (finished !== 1'b1) $display("FAIL done_fin: got %b want 1", finished); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL done_ready: got %b want 0", in_ready); else passed++;
    busy_man = 1'b0;
    in_valid = 1'b1;
    in_cmd = 4'd7;
    tick();
    tick();
    in_valid = 1'b0;
    total++; if (fifo_count !== 5'd0) $display("FAIL done_flush: got %0d want 0", fifo_count); else passed++;
    repeat (20) tick();
    total++; if (seen.size() !== 0) $display("FAIL done_noissue: got %0d issues want 0", seen.size()); else passed++;
    total++; if (issued_cnt !== 8'd0) $display("FAIL done_issued: got %0d want 0", issued_cnt); else passed++;
  endtask

  task automatic test_done_wins();
    do_reset();
    in_valid = 1'b1;
    in_cmd = 4'd12;
    tick();
    in_valid = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (cmd_valid !== 1'b0) $display("FAIL dw_valid: got %b want 0", cmd_valid); else passed++;
    tick();
    total++; if (issued_cnt !== 8'd0) $display("FAIL dw_issued: got %0d want 0", issued_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    busy_auto = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_cmd = 4'(i + 7);
      tick();
    end
    in_valid = 1'b0;
    total++; if (fifo_count !== 5'd3 || busy !== 1'b1)
      $display("FAIL rm_pre: got count=%0d busy=%b want 3/1", fifo_count, busy);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++; if (fifo_count !== 5'd0 || issued_cnt !== 8'd0 || cmd !== 4'd0 ||
                 in_ready !== 1'b1 || cmd_err !== 1'b0 || finished !== 1'b0)
      $display("FAIL rm_async: got cnt=%0d iss=%0d cmd=%0d rdy=%b want 0/0/0/1",
               fifo_count, issued_cnt, cmd, in_ready);
    else passed++;
    tick();
    reset = 1'b0;
    seen.delete();
    repeat (20) tick();
    total++; if (seen.size() !== 0) $display("FAIL rm_quiet: got %0d issues want 0", seen.size()); else passed++;
    in_valid = 1'b1;
    in_cmd = 4'd13;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    total++; if (cmd_valid !== 1'b0) $display("FAIL rm_drop: got %b want 0", cmd_valid); else passed++;
    total++; if (seen.size() !== 1 || seen[0] !== 4'd13)
      $display("FAIL rm_new: got n=%0d want one issue of 13", seen.size());
    else passed++;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_simul();
    test_timeout();
    test_done();
    test_done_wins();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_feeder.md
# lcd_cmd_feeder

Command-buffering sequencer placed directly upstream of `LCD_CTRL`. It accepts 4-bit LCD commands from a host through a valid/ready interface and stores them in a small FIFO. It issues them one at a time on `cmd`/`cmd_valid`, obeying the controller's `busy` handshake. It stops when the controller raises `done` and reports issued-command count and protocol errors.

## Interface
- `DEPTH`, 16: FIFO entries (power of two, ≥2).
- `BUSY_TIMEOUT`, 8: cycles to wait for `busy` to rise after an issue before flagging an error (≥2).
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `in_cmd` input 4: host command word.
- `in_valid` input 1: host offers `in_cmd`.
- `in_ready` output 1: FIFO can accept this cycle.
- `cmd` output 4: command to `LCD_CTRL`.
- `cmd_valid` output 1: one-cycle issue strobe to `LCD_CTRL`.
- `busy` input 1: `LCD_CTRL` busy.
- `done` input 1: `LCD_CTRL` finished.
- `fifo_count` output $clog2(DEPTH)+1: entries held.
- `issued_cnt` output 8: commands issued since reset, wraps 255→0.
- `cmd_err` output 1: sticky; a `busy` timeout occurred.
- `finished` output 1: sticky; `done` has been seen.

## Operation
- Reset values: `in_ready`=1, `cmd`=0, `cmd_valid`=0, `fifo_count`=0, `issued_cnt`=0, `cmd_err`=0, `finished`=0, state IDLE, timer 0, FIFO pointers 0.
- Push: `in_valid && in_ready` at an edge writes `in_cmd` at the write pointer. The pointer wraps modulo DEPTH.
- `in_ready` = !full && !finished (combinational from registered count/flag).
- Pop happens only on issue. Push and pop in the same edge leave `fifo_count` unchanged and are legal at any count, including full (no push, since `in_ready`=0) and empty (no pop).
- No bypass: a command is never issued in the same edge it is pushed.
- FSM states:
  - IDLE: if `!finished && fifo_count>0 && !busy`, load `cmd` with the head entry, assert `cmd_valid` for one cycle, pop, increment `issued_cnt`, clear timer, and go to WAIT_HI. Otherwise stay.
  - WAIT_HI: if `busy`, go to WAIT_LO. Else, if timer == BUSY_TIMEOUT-1, set `cmd_err` and go to IDLE. Else increment timer.
  - WAIT_LO: if `!busy`, go to IDLE.
- `cmd` holds its last issued value between issues. `cmd_valid` is registered and never high for two consecutive cycles.
- `done` (any state, sampled at an edge) sets `finished`. From the next edge onward: no new issue, FIFO flushed (count 0, pointers equal), and the FSM forced to IDLE. If `done` and an issue condition coincide, `done` wins and nothing is issued.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously and any in-flight `cmd_valid` drops immediately.

## Timing
- Push at edge k: `fifo_count` updates after edge k. The earliest `cmd_valid` is high after edge k+1, i.e. one-cycle minimum push-to-issue latency.
- Issue at edge n with `busy` rising at n+1 and falling at edge m: the next `cmd_valid` is at the earliest after edge m+1.
- Timeout path: `busy` low through edges n+1..n+BUSY_TIMEOUT gives `cmd_err`=1 after edge n+BUSY_TIMEOUT. The next issue is possible at n+BUSY_TIMEOUT+1.
- `finished` is visible one cycle after the `done` edge. `in_ready` falls in the same cycle.
- All outputs are registered except `in_ready`.

## Test plan
- Reset release, then push 3,5,0 on consecutive edges with `busy` model (rises 1 cycle after `cmd_valid`, high 4 cycles) → `cmd` sequence 3,5,0, each `cmd_valid` exactly one cycle, `issued_cnt`=3, `fifo_count` returns to 0.
- Push DEPTH+2 commands with `busy` held high → `in_ready`=0 once `fifo_count`=DEPTH, the extra 2 are not accepted. Release `busy` → exactly DEPTH issues, in order.
- Simultaneous push and issue with `fifo_count`=4 → count stays 4, pushed value appears in correct FIFO order.
- `busy` never rises after an issue, BUSY_TIMEOUT=8 → `cmd_err`=1 exactly 8 edges after the issue edge, next queued command issues one cycle later.
- `done` pulsed with 5 entries queued → `finished`=1, `in_ready`=0, `fifo_count`=0, no further `cmd_valid`.
- Assert `reset` while in WAIT_LO with 3 entries → all outputs at reset values immediately, no issue until new pushes after release.
